// File: rtl/blinker_pkg.sv
// Shared constants and types for the LED blinker and its receive-side period meter.
package blinker_pkg;

    localparam int CLK_HZ            = 50_000_000;
    localparam int CNT_W_DEFAULT     = 28;
    // Blinker half-period in cycles; the meter should report this value in loopback.
    localparam int BLINK_HALF_PERIOD = 50_000_000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/blink_period_meter_edge_sync.sv
// Synchronizes an asynchronous input and flags each change of the synchronized level.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] ^ r_hist;

endmodule

// File: rtl/blink_period_meter.sv
// Measures cycles between toggles of an asynchronous blink input, with glitch and
// inactivity-timeout reporting.
module blink_period_meter
    import blinker_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int TIMEOUT     = 100_000_000,
    parameter int MIN_PERIOD  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             main_clk,
    input  logic             reset_n,
    input  logic             blink_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_valid,
    output logic             glitch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);

    logic             w_edge;
    meter_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_glitch;
    logic             r_timeout;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (main_clk),
        .rst_n (reset_n),
        .i_d   (blink_in),
        .o_edge(w_edge)
    );

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_glitch  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_glitch <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First edge after reset or timeout only starts a new interval.
                    if (w_edge) begin
                        r_state   <= MEASURE;
                        r_cnt     <= CNT_W'(1);
                        r_timeout <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_edge) begin
                        if (r_cnt >= MIN_C) begin
                            r_period <= r_cnt;
                            r_valid  <= 1'b1;
                        end else begin
                            r_glitch <= 1'b1;
                        end
                        r_cnt <= CNT_W'(1);
                    end else begin
                        if (r_cnt != TO_C) r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == TO_C - 1'b1) begin
                            r_timeout <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign period_cnt   = r_period;
    assign period_valid = r_valid;
    assign glitch       = r_glitch;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_blink_period_meter.sv
// Randomized scoreboard bench for blink_period_meter against an interval-list reference model.
module tb_blink_period_meter;

    localparam int CNT_W       = 8;
    localparam int TIMEOUT     = 100;
    localparam int MIN_PERIOD  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT_MIN     = 3;
    localparam int LAT_MAX     = 4;

    logic             main_clk = 1'b0;
    logic             reset_n  = 1'b0;
    logic             blink_in = 1'b0;
    logic [CNT_W-1:0] period_cnt;
    logic             period_valid;
    logic             glitch;
    logic             timeout;

    blink_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .MIN_PERIOD (MIN_PERIOD),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .blink_in    (blink_in),
        .period_cnt  (period_cnt),
        .period_valid(period_valid),
        .glitch      (glitch),
        .timeout     (timeout)
    );

    always #5 main_clk = ~main_clk;

    int unsigned cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_glitch;
        int unsigned val;
        int unsigned tog;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          have_ref = 0;
    int unsigned last_tog = 0;
    int unsigned last_val = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: each input change is a point in time; the gap to the previous
    // one decides measurement, glitch, or (gap >= TIMEOUT) a fresh start.
    task automatic model_change();
        int unsigned gap;
        if (have_ref) begin
            gap = cyc - last_tog;
            if (gap < TIMEOUT) begin
                if (gap < MIN_PERIOD) begin
                    sb.push_back('{1'b1, last_val, cyc});
                end else begin
                    last_val = gap;
                    sb.push_back('{1'b0, gap, cyc});
                end
            end
        end
        have_ref = 1;
        last_tog = cyc;
    endtask

    task automatic toggle_in(input int gap);
        repeat (gap) @(negedge main_clk);
        blink_in = ~blink_in;
        model_change();
    endtask

    task automatic release_reset();
        @(negedge main_clk);
        reset_n = 1'b1;
        if (blink_in) model_change();
    endtask

    // Monitor: pops the scoreboard on every strobe
    always @(negedge main_clk) begin : monitor
        exp_t        e;
        int unsigned lat;
        if (reset_n) begin
            if (period_valid || glitch) begin
                chk("valid_glitch_exclusive", period_valid && glitch, 0);
                chk("timeout_valid_exclusive", timeout && period_valid, 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: valid=%0d glitch=%0d period_cnt=%0d, expected no strobe (cycle %0d)",
                             period_valid, glitch, period_cnt, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_is_glitch", glitch, e.is_glitch);
                    chk("period_cnt", period_cnt, e.val);
                    lat = cyc - e.tog;
                    n_checks++;
                    if (lat >= LAT_MIN && lat <= LAT_MAX) n_pass++;
                    else $display("FAIL strobe_latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                end
            end else if (sb.size() > 0 && (cyc - sb[0].tog) > LAT_MAX) begin
                n_checks++;
                $display("FAIL missing_strobe: got none, expected %s with period_cnt=%0d (toggle at cycle %0d)",
                         sb[0].is_glitch ? "glitch" : "period_valid", sb[0].val, sb[0].tog);
                void'(sb.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int gap;
        // Reset held while the input toggles
        repeat (3) begin
            @(negedge main_clk);
            blink_in = ~blink_in;
        end
        @(negedge main_clk);
        chk("reset_period_cnt", period_cnt, 0);
        chk("reset_period_valid", period_valid, 0);
        chk("reset_glitch", glitch, 0);
        chk("reset_timeout", timeout, 0);
        release_reset();

        // Steady 10-cycle toggling; first toggle follows a long quiet gap, so no strobe
        toggle_in(120);
        repeat (5) toggle_in(10);

        // Glitch in the middle
        toggle_in(10);
        toggle_in(2);
        toggle_in(10);

        // Boundary at MIN_PERIOD and just below
        toggle_in(4);
        toggle_in(3);
        toggle_in(10);

        // Timeout
        repeat (TIMEOUT - 2) @(negedge main_clk);
        chk("timeout_before_limit", timeout, 0);
        repeat (7) @(negedge main_clk);
        chk("timeout_risen", timeout, 1);
        repeat (15) @(negedge main_clk);
        chk("timeout_held", timeout, 1);
        toggle_in(1);
        repeat (6) @(negedge main_clk);
        chk("timeout_cleared", timeout, 0);
        toggle_in(10);
        toggle_in(10);

        // Asynchronous reset mid-measurement
        toggle_in(10);
        repeat (50) @(negedge main_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_period_cnt", period_cnt, 0);
        chk("async_rst_period_valid", period_valid, 0);
        chk("async_rst_glitch", glitch, 0);
        chk("async_rst_timeout", timeout, 0);
        sb.delete();
        have_ref = 0;
        last_val = 0;
        @(negedge main_clk);
        blink_in = ~blink_in;
        release_reset();
        toggle_in(12);
        toggle_in(12);

        // Randomized intervals, occasionally long enough to time out
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) gap = $urandom_range(TIMEOUT, TIMEOUT + 30);
            else gap = $urandom_range(1, 15);
            toggle_in(gap);
        end

        repeat (12) @(negedge main_clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
